// File: rtl/qupls_rat_backout_walker.sv
// qupls_rat_backout_walker
// Walks the ROB backwards after a branch mispredict, from the youngest
// same-group entry down to (but excluding) the branch. Up to LANES RAT
// restore writes are issued per cycle. An older mispredict that arrives
// mid-walk retargets the walk, and a checkpoint restore can cancel it.
//
// Interface semantics: backout and restore are single-cycle request pulses
// sampled on the rising clock edge; there is no back-pressure. bo_wr[k] is
// a one-cycle qualifier for lane k's bo_areg/bo_preg/bo_nreg, and bo_done
// is a one-cycle completion pulse. stall tells the front end to hold off
// while a walk is pending, running, or just finishing.
module qupls_rat_backout_walker #(
    parameter int ROB_ENTRIES = 16,
    parameter int GRP_SIZE    = 4,
    parameter int LANES       = 2,
    parameter int GRP_W       = 6,
    parameter int SN_W        = 8,
    parameter int AREG_W      = 7,
    parameter int PREG_W      = 9,
    localparam int NDX_W      = $clog2(ROB_ENTRIES)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          backout,
    input  logic [NDX_W-1:0]              fcu_id,
    input  logic [SN_W-1:0]               fcu_sn,
    input  logic [ROB_ENTRIES*GRP_W-1:0]  rob_grp,
    input  logic [ROB_ENTRIES-1:0]        rob_hasrt,
    input  logic [ROB_ENTRIES*AREG_W-1:0] rob_art,
    input  logic [ROB_ENTRIES*PREG_W-1:0] rob_prt,
    input  logic [ROB_ENTRIES*PREG_W-1:0] rob_nrt,
    input  logic                          restore,
    input  logic [SN_W-1:0]               restore_sn,
    output logic [LANES-1:0]              bo_wr,
    output logic [LANES*AREG_W-1:0]       bo_areg,
    output logic [LANES*PREG_W-1:0]       bo_preg,
    output logic [LANES*PREG_W-1:0]       bo_nreg,
    output logic                          bo_done,
    output logic [NDX_W-1:0]              bo_count,
    output logic                          stall,
    output logic [1:0]                    dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WALK  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [NDX_W-1:0]  ptr, ptr_n;
    logic [NDX_W-1:0]  tgt, tgt_n;
    logic [SN_W-1:0]   tsn, tsn_n;
    logic              emit;
    logic              cnt_load;
    logic              done_n;

    // Per-entry views of the flattened ROB buses
    logic [GRP_W-1:0]  grp_e [ROB_ENTRIES];
    logic [AREG_W-1:0] art_e [ROB_ENTRIES];
    logic [PREG_W-1:0] prt_e [ROB_ENTRIES];
    logic [PREG_W-1:0] nrt_e [ROB_ENTRIES];

    for (genvar i = 0; i < ROB_ENTRIES; i++) begin : g_unpack
        assign grp_e[i] = rob_grp[i*GRP_W +: GRP_W];
        assign art_e[i] = rob_art[i*AREG_W +: AREG_W];
        assign prt_e[i] = rob_prt[i*PREG_W +: PREG_W];
        assign nrt_e[i] = rob_nrt[i*PREG_W +: PREG_W];
    end

    // Group scan: count consecutive entries past the branch in its group
    logic [NDX_W-1:0] m_scan;
    logic [NDX_W-1:0] scan_idx;
    logic             scan_run;

    // Find m: the scan stops at the first entry with a different group tag
    always_comb begin
        m_scan   = '0;
        scan_run = 1'b1;
        scan_idx = fcu_id;
        for (int j = 1; j < GRP_SIZE; j++) begin
            scan_idx = fcu_id + NDX_W'(j);
            if (scan_run && (grp_e[scan_idx] == grp_e[fcu_id]))
                m_scan = NDX_W'(j);
            else
                scan_run = 1'b0;
        end
    end

    // Start, retarget and restore decisions (sequence compares are modulo 2^SN_W)
    logic             start;
    logic             retarget;
    logic             rs_abort;
    logic [SN_W-1:0]  sn_diff;
    logic [SN_W-1:0]  rs_diff;
    logic [NDX_W-1:0] base_ptr;
    logic [NDX_W-1:0] base_tgt;
    logic [NDX_W-1:0] dist_base;

    assign start     = (state == S_IDLE) && backout && !restore;
    assign sn_diff   = tsn - fcu_sn;
    assign retarget  = (state == S_WALK) && backout && !restore &&
                       (sn_diff != '0) && !sn_diff[SN_W-1];
    assign rs_diff   = tsn - restore_sn;
    assign rs_abort  = !rs_diff[SN_W-1];
    // On a start the first lanes are issued straight from the scan result,
    // so the first write appears one cycle after the mispredict.
    assign base_ptr  = start ? (fcu_id + m_scan) : ptr;
    assign base_tgt  = (start || retarget) ? fcu_id : tgt;
    assign dist_base = base_ptr - base_tgt;

    // Lane selection: lane k covers base_ptr-k while it stays above the branch
    logic [NDX_W-1:0] lane_idx [LANES];
    logic [LANES-1:0] lane_ok;
    logic [NDX_W-1:0] lane_cnt;

    // Compute lane indices, lane validity and the number of valid lanes
    always_comb begin
        lane_cnt = '0;
        lane_ok  = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_idx[k] = base_ptr - NDX_W'(k);
            lane_ok[k]  = (dist_base > NDX_W'(k)) && rob_hasrt[lane_idx[k]];
            lane_cnt    = lane_cnt + {{(NDX_W-1){1'b0}}, lane_ok[k]};
        end
    end

    // Next-state and control decode
    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        tgt_n    = tgt;
        tsn_n    = tsn;
        emit     = 1'b0;
        cnt_load = 1'b0;
        done_n   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    tgt_n    = fcu_id;
                    tsn_n    = fcu_sn;
                    cnt_load = 1'b1;
                    if (m_scan == '0) begin
                        done_n = 1'b1;
                    end else begin
                        emit    = 1'b1;
                        ptr_n   = base_ptr - NDX_W'(LANES);
                        state_n = (dist_base <= NDX_W'(LANES)) ? S_DRAIN : S_WALK;
                    end
                end
            end
            S_WALK: begin
                if (restore) begin
                    // A younger restore only costs this cycle's writes
                    if (rs_abort) begin
                        done_n  = 1'b1;
                        state_n = S_IDLE;
                    end
                end else begin
                    if (retarget) begin
                        tgt_n = fcu_id;
                        tsn_n = fcu_sn;
                    end
                    emit  = 1'b1;
                    ptr_n = base_ptr - NDX_W'(LANES);
                    if (dist_base <= NDX_W'(LANES))
                        state_n = S_DRAIN;
                end
            end
            S_DRAIN: begin
                done_n  = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State register and walk bookkeeping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            ptr   <= '0;
            tgt   <= '0;
            tsn   <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            tgt   <= tgt_n;
            tsn   <= tsn_n;
        end
    end

    // Registered RAT restore outputs; unwritten lanes keep their last values
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bo_wr    <= '0;
            bo_areg  <= '0;
            bo_preg  <= '0;
            bo_nreg  <= '0;
            bo_done  <= 1'b0;
            bo_count <= '0;
        end else begin
            bo_wr   <= '0;
            bo_done <= done_n;
            if (emit) begin
                bo_wr <= lane_ok;
                for (int k = 0; k < LANES; k++) begin
                    if (lane_ok[k]) begin
                        bo_areg[k*AREG_W +: AREG_W] <= art_e[lane_idx[k]];
                        bo_preg[k*PREG_W +: PREG_W] <= prt_e[lane_idx[k]];
                        bo_nreg[k*PREG_W +: PREG_W] <= nrt_e[lane_idx[k]];
                    end
                end
            end
            if (cnt_load)
                bo_count <= lane_cnt;
            else if (emit)
                bo_count <= bo_count + lane_cnt;
        end
    end

    assign stall     = backout | (state != S_IDLE) | bo_done;
    assign dbg_state = state;

endmodule

// File: tb/tb_qupls_rat_backout_walker.sv
// Directed testbench for qupls_rat_backout_walker: a per-cycle vector table
// with hand-computed expectations, plus a hand-written reset-mid-walk sequence.
module tb_qupls_rat_backout_walker;

    localparam int ROB_ENTRIES = 16;
    localparam int GRP_SIZE    = 4;
    localparam int LANES       = 2;
    localparam int GRP_W       = 6;
    localparam int SN_W        = 8;
    localparam int AREG_W      = 7;
    localparam int PREG_W      = 9;
    localparam int NDX_W       = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic                          backout = 1'b0;
    logic [NDX_W-1:0]              fcu_id = '0;
    logic [SN_W-1:0]               fcu_sn = '0;
    logic [ROB_ENTRIES*GRP_W-1:0]  rob_grp;
    logic [ROB_ENTRIES-1:0]        rob_hasrt;
    logic [ROB_ENTRIES*AREG_W-1:0] rob_art;
    logic [ROB_ENTRIES*PREG_W-1:0] rob_prt;
    logic [ROB_ENTRIES*PREG_W-1:0] rob_nrt;
    logic                          restore = 1'b0;
    logic [SN_W-1:0]               restore_sn = '0;
    logic [LANES-1:0]              bo_wr;
    logic [LANES*AREG_W-1:0]       bo_areg;
    logic [LANES*PREG_W-1:0]       bo_preg;
    logic [LANES*PREG_W-1:0]       bo_nreg;
    logic                          bo_done;
    logic [NDX_W-1:0]              bo_count;
    logic                          stall;
    logic [1:0]                    dbg_state;

    logic [GRP_W-1:0]  grp_a   [ROB_ENTRIES];
    logic              hasrt_a [ROB_ENTRIES];
    logic [AREG_W-1:0] art_a   [ROB_ENTRIES];
    logic [PREG_W-1:0] prt_a   [ROB_ENTRIES];
    logic [PREG_W-1:0] nrt_a   [ROB_ENTRIES];

    always_comb begin
        for (int i = 0; i < ROB_ENTRIES; i++) begin
            rob_grp[i*GRP_W +: GRP_W]   = grp_a[i];
            rob_hasrt[i]                = hasrt_a[i];
            rob_art[i*AREG_W +: AREG_W] = art_a[i];
            rob_prt[i*PREG_W +: PREG_W] = prt_a[i];
            rob_nrt[i*PREG_W +: PREG_W] = nrt_a[i];
        end
    end

    qupls_rat_backout_walker #(
        .ROB_ENTRIES(ROB_ENTRIES), .GRP_SIZE(GRP_SIZE), .LANES(LANES),
        .GRP_W(GRP_W), .SN_W(SN_W), .AREG_W(AREG_W), .PREG_W(PREG_W)
    ) dut (
        .clk(clk), .rst(rst), .backout(backout), .fcu_id(fcu_id), .fcu_sn(fcu_sn),
        .rob_grp(rob_grp), .rob_hasrt(rob_hasrt), .rob_art(rob_art),
        .rob_prt(rob_prt), .rob_nrt(rob_nrt), .restore(restore),
        .restore_sn(restore_sn), .bo_wr(bo_wr), .bo_areg(bo_areg),
        .bo_preg(bo_preg), .bo_nreg(bo_nreg), .bo_done(bo_done),
        .bo_count(bo_count), .stall(stall), .dbg_state(dbg_state)
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- ROB setup driver ----------------
    // Distinct default groups; art/prt/nrt derive from the index so every
    // lane write identifies its source entry.
    task automatic setup_rob(input int code);
        for (int i = 0; i < ROB_ENTRIES; i++) begin
            grp_a[i]   = GRP_W'(i + 32);
            hasrt_a[i] = 1'b1;
            art_a[i]   = AREG_W'(i + 16);
            prt_a[i]   = PREG_W'(i + 100);
            nrt_a[i]   = PREG_W'(i + 200);
        end
        case (code)
            1: for (int i = 5; i <= 8; i++) grp_a[i] = 6'd3;
            2: begin grp_a[14] = 6'd7; grp_a[15] = 6'd7; grp_a[0] = 6'd7; end
            4: for (int i = 4; i <= 7; i++) grp_a[i] = 6'd5;
            5: begin
                for (int i = 4; i <= 7; i++) grp_a[i] = 6'd5;
                hasrt_a[6] = 1'b0;
            end
            default: ;
        endcase
    endtask

    // ---------------- vector table ----------------
    // One row per cycle: inputs driven this cycle, outputs expected this cycle.
    typedef struct {
        int         setup;
        logic       bo;
        logic [3:0] id;
        logic [7:0] sn;
        logic       rs;
        logic [7:0] rsn;
        logic [1:0] wr;
        logic [3:0] i0;
        logic [3:0] i1;
        logic       done;
        logic [3:0] cnt;
        logic       stl;
        logic [1:0] st;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int setup, input int bo, input int id, input int sn,
                                input int rs, input int rsn, input int wr, input int i0,
                                input int i1, input int done, input int cnt, input int stl,
                                input int st);
        vec_t v;
        v.setup = setup;   v.bo  = 1'(bo);   v.id = 4'(id);   v.sn   = 8'(sn);
        v.rs    = 1'(rs);  v.rsn = 8'(rsn);  v.wr = 2'(wr);   v.i0   = 4'(i0);
        v.i1    = 4'(i1);  v.done = 1'(done); v.cnt = 4'(cnt); v.stl = 1'(stl);
        v.st    = 2'(st);
        return v;
    endfunction

    task automatic check_lane(input string tag, input int k, input logic [3:0] idx);
        check({tag, "_areg"}, 32'(bo_areg[k*AREG_W +: AREG_W]), 32'(art_a[idx]));
        check({tag, "_preg"}, 32'(bo_preg[k*PREG_W +: PREG_W]), 32'(prt_a[idx]));
        check({tag, "_nreg"}, 32'(bo_nreg[k*PREG_W +: PREG_W]), 32'(nrt_a[idx]));
    endtask

    initial begin
        //            set bo id sn rs rsn wr i0 i1 dn cnt stl st
        // A: group 5..8, first writes {8,7} then {6}
        tbl.push_back(mk(1, 1, 5, 10, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 3, 8, 7, 0, 2, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 6, 0, 0, 3, 1, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0));
        // B: wrap 14,15,0
        tbl.push_back(mk(2, 1, 14, 30, 0, 0, 0, 0, 0, 0, 3, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 3, 0, 15, 0, 2, 1, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0));
        // C: next entry in a different group
        tbl.push_back(mk(3, 1, 9, 40, 0, 0, 0, 0, 0, 0, 2, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // D: retarget to id 2 (sn 18), then younger sn 25 ignored
        tbl.push_back(mk(4, 1, 4, 20, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 2, 18, 0, 0, 3, 7, 6, 0, 2, 1, 1));
        tbl.push_back(mk(0, 1, 4, 25, 0, 0, 3, 5, 4, 0, 4, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 5, 1, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0));
        // E: entry 6 has no dest; older restore aborts in first WALK cycle
        tbl.push_back(mk(5, 1, 4, 20, 0, 0, 0, 0, 0, 0, 5, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 19, 1, 7, 0, 0, 1, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        // F: younger restore costs one cycle, walk completes
        tbl.push_back(mk(4, 1, 4, 20, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 22, 3, 7, 6, 0, 2, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 3, 1, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0));
        // G: restore and backout together in IDLE, backout dropped
        tbl.push_back(mk(4, 1, 4, 20, 1, 20, 0, 0, 0, 0, 3, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0));
    end

    // ---------------- main sequence ----------------
    initial begin
        string tag;
        setup_rob(0);

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_wr",    32'(bo_wr),     32'd0);
        check("rst_done",  32'(bo_done),   32'd0);
        check("rst_count", 32'(bo_count),  32'd0);
        check("rst_areg",  32'(bo_areg),   32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        check("rst_stall", 32'(stall),     32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven vectors
        for (int r = 0; r < tbl.size(); r++) begin
            @(negedge clk);
            if (tbl[r].setup != 0) setup_rob(tbl[r].setup);
            backout    = tbl[r].bo;
            fcu_id     = tbl[r].id;
            fcu_sn     = tbl[r].sn;
            restore    = tbl[r].rs;
            restore_sn = tbl[r].rsn;
            #1;
            tag = $sformatf("row%0d", r);
            check({tag, "_wr"},    32'(bo_wr),     32'(tbl[r].wr));
            check({tag, "_done"},  32'(bo_done),   32'(tbl[r].done));
            check({tag, "_count"}, 32'(bo_count),  32'(tbl[r].cnt));
            check({tag, "_stall"}, 32'(stall),     32'(tbl[r].stl));
            check({tag, "_state"}, 32'(dbg_state), 32'(tbl[r].st));
            if (tbl[r].wr[0]) check_lane({tag, "_l0"}, 0, tbl[r].i0);
            if (tbl[r].wr[1]) check_lane({tag, "_l1"}, 1, tbl[r].i1);
        end

        // Reset asserted mid-walk
        @(negedge clk);
        setup_rob(4);
        backout = 1'b1; fcu_id = 4'd4; fcu_sn = 8'd20; restore = 1'b0;
        @(negedge clk);
        backout = 1'b0;
        #1;
        check("mid_pre_wr",    32'(bo_wr),     32'd3);
        check("mid_pre_state", 32'(dbg_state), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_wr",    32'(bo_wr),     32'd0);
        check("mid_state", 32'(dbg_state), 32'd0);
        check("mid_count", 32'(bo_count),  32'd0);
        check("mid_areg",  32'(bo_areg),   32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("mid_no_done", 32'(bo_done), 32'd0);
        check("mid_stall",   32'(stall),   32'd0);

        // Next backout after reset runs normally
        @(negedge clk);
        setup_rob(1);
        backout = 1'b1; fcu_id = 4'd5; fcu_sn = 8'd50;
        @(negedge clk);
        backout = 1'b0;
        #1;
        check("post_wr",    32'(bo_wr),    32'd3);
        check_lane("post_l0", 0, 4'd8);
        check_lane("post_l1", 1, 4'd7);
        @(negedge clk);
        #1;
        check("post2_wr",    32'(bo_wr),    32'd1);
        check_lane("post2_l0", 0, 4'd6);
        check("post2_l1_hold", 32'(bo_areg[AREG_W +: AREG_W]), 32'(art_a[7]));
        @(negedge clk);
        #1;
        check("post_done",  32'(bo_done),  32'd1);
        check("post_count", 32'(bo_count), 32'd3);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/qupls_rat_backout_walker.md
Name: qupls_rat_backout_walker

Overview:
- Multi-lane successor to the RAT backout machine. On a branch mispredict it walks the ROB backwards, from the youngest same-group entry down to the branch, and issues up to LANES RAT restore writes per cycle (old mapping pRt, freed nRt).
- Sits between the FCU/ROB and the RAT write-back ports.
- Adds three behaviours:
  - parametrised group size and lane count;
  - retargeting to an older mispredict that arrives mid-walk;
  - cancellation by checkpoint restore with wrap-aware sequence compare.

Parameters:
ROB_ENTRIES, 16, ROB depth; power of two, >= 2*GRP_SIZE
GRP_SIZE, 4, max instructions per fetch group; scan window = GRP_SIZE-1 entries past the branch
LANES, 2, RAT backout writes per cycle; 1..GRP_SIZE
GRP_W, 6, group tag width
SN_W, 8, sequence-number width; compared modulo 2^SN_W
AREG_W, 7, architectural register number width
PREG_W, 9, physical register number width
(NDX_W = clog2(ROB_ENTRIES), derived)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
backout  in  1  mispredict pulse
fcu_id  in  NDX_W  ROB index of mispredicted branch
fcu_sn  in  SN_W  sequence number of that branch
rob_grp  in  ROB_ENTRIES*GRP_W  group tag per entry
rob_hasrt  in  ROB_ENTRIES  entry writes a register
rob_art  in  ROB_ENTRIES*AREG_W  arch dest per entry
rob_prt  in  ROB_ENTRIES*PREG_W  previous mapping per entry
rob_nrt  in  ROB_ENTRIES*PREG_W  newly allocated preg per entry
restore  in  1  checkpoint restore pulse
restore_sn  in  SN_W  sequence number of restore point
bo_wr  out  LANES  lane write enables; lane 0 = youngest
bo_areg  out  LANES*AREG_W
bo_preg  out  LANES*PREG_W
bo_nreg  out  LANES*PREG_W
bo_done  out  1  one-cycle pulse when a walk completes or is aborted
bo_count  out  NDX_W  entries backed out by the last walk (hasrt only)
stall  out  1  front-end stall

Behaviour:
- Reset: asynchronous, rst low. State IDLE; bo_wr=0; bo_areg/preg/nreg=0; bo_done=0; bo_count=0; internal ptr/tgt/sn=0.
- dist(i) = (i - tgt) mod ROB_ENTRIES.
- States: IDLE, WALK, DRAIN.
- IDLE, backout=1:
  - tgt<=fcu_id, tsn<=fcu_sn.
  - ptr<=fcu_id+m, where m is the largest m in 1..GRP_SIZE-1 such that entries fcu_id+1..fcu_id+m all carry rob_grp[fcu_id]. The scan stops at the first mismatch.
  - If m exists, go to WALK. Otherwise stay IDLE and pulse bo_done next cycle with bo_count=0.
- WALK, each cycle:
  - Lane k targets ptr-k. The lane is valid iff dist(ptr)-k >= 1 and rob_hasrt of that entry is set.
  - Outputs are registered and appear the next cycle.
  - bo_count accumulates the number of valid lanes.
  - ptr<=ptr-LANES. If dist(ptr) <= LANES, go to DRAIN.
- DRAIN: the last writes are on the outputs. bo_done=1 for one cycle, then IDLE.
- Latency: walk of d entries finishes in ceil(d/LANES) WALK cycles plus 1 DRAIN; first write is visible 1 cycle after backout.
- The branch entry itself is never written back.
- Outputs not enabled by bo_wr hold their previous values; bo_wr deasserts every cycle it is not driven.
- backout during WALK:
  - If fcu_sn is older than tsn ((tsn-fcu_sn) mod 2^SN_W in 1..2^(SN_W-1)-1): retarget tgt<=fcu_id, tsn<=fcu_sn. Continue from the current ptr (the new range is a superset). bo_count is not reset.
  - Otherwise the pulse is ignored.
- restore (any state except IDLE-without-backout):
  - Same cycle: no bo_wr is issued for that cycle.
  - If restore_sn is older-or-equal to tsn (wrap-aware compare): abort, bo_done pulse next cycle, then IDLE.
  - If restore_sn is younger: the walk continues unaffected.
- restore and backout in the same IDLE cycle: restore has priority and backout is dropped.
- Wrap-around: all ROB index arithmetic is modulo ROB_ENTRIES. The scan and walk cross index ROB_ENTRIES-1→0 seamlessly.
- stall = backout | (state != IDLE) | bo_done (combinational).
- Reset mid-walk: immediate IDLE, all outputs cleared; no bo_done pulse.

Test Plan:
- LANES=2, GRP_SIZE=4, fcu_id=5, entries 5..8 group 3 with hasrt=1 → writes at T+1 for {8,7}, at T+2 for {6}; bo_done at T+3; bo_count=3.
- Wrap case: fcu_id=14, entries 14,15,0 same group, entry 1 different → lanes {0,15} at T+1; done T+2; count=2.
- fcu_id=9, entry 10 in a different group → no bo_wr, bo_done at T+1, count=0; stall high for T and T+1 only.
- Walk from fcu_id=4 (sn=20), then backout fcu_id=2 (sn=18) during WALK → walk continues to entry 3 with no write to 2; a later backout sn=25 is ignored.
- restore restore_sn=19 (older than tsn=20) in the first WALK cycle → no further bo_wr, bo_done next cycle. Repeat with restore_sn=22 → walk completes normally.
- Assert rst low mid-walk → bo_wr=0 within the same cycle, state IDLE; next backout is processed normally.
